// File: rtl/trace_capture_ctrl.sv
// trace_capture_ctrl: arm/sync/trigger/delay/capture sequencer gating trace-record writes into the capture FIFO
module trace_capture_ctrl #(
  parameter int pCOUNT_WIDTH = 32,
  parameter int pDELAY_WIDTH = 16
) (
  input  logic                    trace_clk,
  input  logic                    reset_n,
  input  logic                    I_arm,
  input  logic [1:0]              I_trig_source,
  input  logic                    I_m3_trig,
  input  logic                    I_match_trig,
  input  logic                    I_userio_trig,
  input  logic [pDELAY_WIDTH-1:0] I_trig_delay,
  input  logic [pCOUNT_WIDTH-1:0] I_capture_len,
  input  logic                    I_synchronized,
  input  logic                    I_data_valid,
  input  logic                    I_fifo_full,
  output logic                    O_fifo_wr,
  output logic                    O_arm,
  output logic                    O_capturing,
  output logic                    O_done,
  output logic                    O_overflow,
  output logic                    O_trig_out,
  output logic [2:0]              O_state,
  output logic [pCOUNT_WIDTH-1:0] O_capture_count
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_SYNC = 3'd1;
  localparam logic [2:0] WAIT_TRIG = 3'd2;
  localparam logic [2:0] DELAY     = 3'd3;
  localparam logic [2:0] CAPTURE   = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  logic [2:0]              state_q, state_d;
  logic                    arm_q, arm_d;
  logic [2:0]              hist_q, hist_d;
  logic [1:0]              src_q, src_d;
  logic [pDELAY_WIDTH-1:0] delay_q, delay_d;
  logic [pDELAY_WIDTH-1:0] dcnt_q, dcnt_d;
  logic [pCOUNT_WIDTH-1:0] len_q, len_d;
  logic [pCOUNT_WIDTH-1:0] count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    sel_now, sel_prev, trig, wr, drop, last, trig_out;
  logic [pCOUNT_WIDTH:0]   count_inc;

  // Trigger selection: rising edge of the latched source; immediate source always fires
  always_comb begin
    sel_now  = src_q == 2'd0 ? I_m3_trig : src_q == 2'd1 ? I_match_trig : I_userio_trig;
    sel_prev = src_q == 2'd0 ? hist_q[0] : src_q == 2'd1 ? hist_q[1] : hist_q[2];
    trig     = src_q == 2'd2 ? 1'b1 : sel_now & ~sel_prev;
  end

  // Write gating and end-of-length detection, compared at full width so len never wraps
  always_comb begin
    wr        = (state_q == CAPTURE) & I_data_valid & ~I_fifo_full;
    drop      = (state_q == CAPTURE) & I_data_valid & I_fifo_full;
    count_inc = {1'b0, count_q} + {{pCOUNT_WIDTH{1'b0}}, 1'b1};
    last      = wr && (len_q != '0) && (count_inc == {1'b0, len_q});
  end

  // Sequencer next-state; disarm overrides every other transition
  always_comb begin
    state_d  = state_q;
    arm_d    = I_arm;
    hist_d   = {I_userio_trig, I_match_trig, I_m3_trig};
    src_d    = src_q;
    delay_d  = delay_q;
    dcnt_d   = dcnt_q;
    len_d    = len_q;
    count_d  = wr ? (&count_q ? count_q : count_q + 1'b1) : count_q;
    ovf_d    = ovf_q | drop;
    trig_out = 1'b0;
    if (state_q != IDLE && !I_arm) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (I_arm && !arm_q) begin
          src_d   = I_trig_source;
          delay_d = I_trig_delay;
          len_d   = I_capture_len;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = WAIT_SYNC;
        end
        WAIT_SYNC: state_d = I_synchronized ? WAIT_TRIG : WAIT_SYNC;
        WAIT_TRIG: if (!I_synchronized) state_d = WAIT_SYNC;
          else if (trig) begin
            trig_out = 1'b1;
            dcnt_d   = '0;
            state_d  = delay_q != '0 ? DELAY : CAPTURE;
          end
        DELAY: begin
          dcnt_d  = dcnt_q + 1'b1;
          state_d = dcnt_q == delay_q - 1'b1 ? CAPTURE : DELAY;
        end
        CAPTURE: state_d = (drop || last) ? DONE : CAPTURE;
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and configuration registers with synchronous active-low reset
  always_ff @(posedge trace_clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      arm_q   <= 1'b0;
      hist_q  <= '0;
      src_q   <= '0;
      delay_q <= '0;
      dcnt_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      hist_q  <= hist_d;
      src_q   <= src_d;
      delay_q <= delay_d;
      dcnt_q  <= dcnt_d;
      len_q   <= len_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign O_fifo_wr       = wr;
  assign O_arm           = state_q != IDLE;
  assign O_capturing     = state_q == CAPTURE;
  assign O_done          = state_q == DONE;
  assign O_overflow      = ovf_q;
  assign O_trig_out      = trig_out;
  assign O_state         = state_q;
  assign O_capture_count = count_q;
endmodule
